// File: rtl/riscv_acc_wb_seq.sv
// riscv_acc_wb_seq: writes a wide accelerator result to memory word by word while halting the core
module riscv_acc_wb_seq #(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 32,
  parameter int STRIDE    = 4,
  parameter int REVERSE   = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [ADDR_W-1:0]             base_addr_i,
  input  logic [NUM_WORDS*DATA_W-1:0]   result_i,
  output logic                          mem_req_o,
  input  logic                          mem_gnt_i,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  output logic                          mem_we_o,
  output logic                          halt_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);
  localparam int IDX_W = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam int CNT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, REQ, DONE, ABORT} state_t;
  state_t state, state_nxt;
  logic [NUM_WORDS*DATA_W-1:0] snap;
  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0] idx, widx;
  logic [CNT_W-1:0] wait_cnt;
  logic last, expire, req;
  assign last   = idx == IDX_W'(NUM_WORDS - 1);
  assign expire = TIMEOUT != 0 && wait_cnt == CNT_W'(TIMEOUT - 1);
  assign widx   = REVERSE != 0 ? IDX_W'(NUM_WORDS - 1) - idx : idx;
  assign req    = state == REQ;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start_i ? REQ : IDLE;
      REQ:     state_nxt = mem_gnt_i ? (last ? DONE : REQ) : (expire ? ABORT : REQ);
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      snap     <= '0;
      addr     <= '0;
      idx      <= '0;
      wait_cnt <= '0;
    end else if (state == IDLE && start_i) begin
      snap     <= result_i;
      addr     <= base_addr_i;
      idx      <= '0;
      wait_cnt <= '0;
    end else if (req && mem_gnt_i) begin
      addr     <= addr + ADDR_W'(STRIDE);
      idx      <= idx + 1'b1;
      wait_cnt <= '0;
    end else if (req) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
  assign mem_req_o   = req;
  assign mem_we_o    = req;
  assign mem_addr_o  = req ? addr : '0;
  assign mem_wdata_o = req ? snap[int'(widx)*DATA_W +: DATA_W] : '0;
  assign halt_o      = state != IDLE;
  assign busy_o      = state != IDLE;
  assign done_o      = state == DONE;
  assign err_o       = state == ABORT;
endmodule

// File: tb/tb_riscv_acc_wb_seq.sv
// tb_riscv_acc_wb_seq: randomized check of two sequencer configurations against a transfer-level model
module tb_riscv_acc_wb_seq;
  localparam int NW = 4;
  localparam int STRIDE = 4;
  logic clk = 0, rst = 1;
  logic start [2];
  logic [31:0] base [2];
  logic [127:0] res [2];
  logic gnt [2];
  logic req_o [2], we_o [2], halt_o [2], busy_o [2], done_o [2], err_o [2];
  logic [31:0] addr_o [2], wdata_o [2];
  int rev [2] = '{0, 1};
  int to [2] = '{255, 4};
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  riscv_acc_wb_seq dut0 (
    .clk(clk), .rst(rst), .start_i(start[0]), .base_addr_i(base[0]), .result_i(res[0]),
    .mem_req_o(req_o[0]), .mem_gnt_i(gnt[0]), .mem_addr_o(addr_o[0]), .mem_wdata_o(wdata_o[0]),
    .mem_we_o(we_o[0]), .halt_o(halt_o[0]), .busy_o(busy_o[0]), .done_o(done_o[0]), .err_o(err_o[0])
  );
  riscv_acc_wb_seq #(.REVERSE(1), .TIMEOUT(4)) dut1 (
    .clk(clk), .rst(rst), .start_i(start[1]), .base_addr_i(base[1]), .result_i(res[1]),
    .mem_req_o(req_o[1]), .mem_gnt_i(gnt[1]), .mem_addr_o(addr_o[1]), .mem_wdata_o(wdata_o[1]),
    .mem_we_o(we_o[1]), .halt_o(halt_o[1]), .busy_o(busy_o[1]), .done_o(done_o[1]), .err_o(err_o[1])
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_outs(input int d, input logic rq, input logic [31:0] a, input logic [31:0] wd,
                            input logic hb, input logic dn, input logic er);
    check($sformatf("d%0d_req", d), 64'(req_o[d]), 64'(rq));
    check($sformatf("d%0d_we", d), 64'(we_o[d]), 64'(rq));
    check($sformatf("d%0d_addr", d), 64'(addr_o[d]), 64'(a));
    check($sformatf("d%0d_wdata", d), 64'(wdata_o[d]), 64'(wd));
    check($sformatf("d%0d_halt", d), 64'(halt_o[d]), 64'(hb));
    check($sformatf("d%0d_busy", d), 64'(busy_o[d]), 64'(hb));
    check($sformatf("d%0d_done", d), 64'(done_o[d]), 64'(dn));
    check($sformatf("d%0d_err", d), 64'(err_o[d]), 64'(er));
  endtask
  function automatic logic [31:0] word(input logic [127:0] r, input int i);
    return r[i*32 +: 32];
  endfunction
  // mode: 0 grant always, 1 random grant, 2 never grant, 3 grant after three idle cycles
  task automatic xfer(input int d, input logic [31:0] b, input logic [127:0] r, input int mode, input int rst_at);
    int k = 0, w = 0, guard = 0;
    bit ab = 0;
    @(negedge clk);
    check_outs(d, 0, 0, 0, 0, 0, 0);
    start[d] = 1; base[d] = b; res[d] = r; gnt[d] = 0;
    @(negedge clk);
    while (k < NW && !ab && guard < 2000) begin
      check_outs(d, 1, b + 32'(k * STRIDE), word(r, rev[d] != 0 ? NW - 1 - k : k), 1, 0, 0);
      start[d] = 1'($urandom_range(0, 1));
      base[d] = $urandom;
      res[d] = {$urandom, $urandom, $urandom, $urandom};
      gnt[d] = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : mode == 3 ? (w == 3) : 1'b0;
      if (gnt[d]) begin
        k++;
        w = 0;
      end else begin
        w++;
        ab = to[d] != 0 && w == to[d];
      end
      guard++;
      @(negedge clk);
      if (rst_at != 0 && k == rst_at) break;
    end
    if (guard >= 2000) check("guard", 64'(guard), 64'(0));
    if (rst_at != 0) begin
      rst = 1; start[d] = 0; gnt[d] = 1;
      @(negedge clk);
      rst = 0;
      check_outs(d, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check_outs(d, 0, 0, 0, 0, 0, 0);
      gnt[d] = 0;
      return;
    end
    check_outs(d, 0, 0, 0, 1, !ab, ab);
    start[d] = 1; gnt[d] = 0;
    @(negedge clk);
    start[d] = 0;
    check_outs(d, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    logic [127:0] pat = 128'h44444444_33333333_22222222_11111111;
    for (int i = 0; i < 2; i++) begin
      start[i] = 0; base[i] = 0; res[i] = 0; gnt[i] = 0;
    end
    repeat (2) @(negedge clk);
    check_outs(0, 0, 0, 0, 0, 0, 0);
    check_outs(1, 0, 0, 0, 0, 0, 0);
    rst = 0;
    xfer(0, 32'h1000_0000, pat, 0, 0);
    xfer(1, 32'h1000_0000, pat, 0, 0);
    xfer(0, 32'h1000_0000, pat, 3, 0);
    xfer(1, 32'h2000_0100, pat, 3, 0);
    xfer(1, 32'h3000_0000, pat, 2, 0);
    xfer(1, 32'h3000_0000, pat, 0, 0);
    xfer(0, 32'hFFFF_FFF8, pat, 0, 0);
    xfer(0, 32'h1000_0000, pat, 0, 2);
    xfer(0, 32'h4000_0000, pat, 0, 0);
    xfer(0, 32'h5000_0000, pat, 2, 0);
    for (int i = 0; i < 30; i++) begin
      int d = $urandom_range(0, 1);
      int m = $urandom_range(0, 3);
      if (d == 0 && m == 2) m = 1;
      xfer(d, $urandom, {$urandom, $urandom, $urandom, $urandom}, m, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
